// File: rtl/mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// The state encoding lives here so that the top and any debug logic agree on it.
package mp_add_pkg;

  localparam int ADDER_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtract is a + ~b + 1, so the chain always starts with carry set.
  function automatic logic init_carry(input logic op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Requester-side handshake and operand/result bus for mp_add_seq.
// The master is the requester; the slave is the sequencer.
interface mp_add_seq_if #(
  parameter int WORDS = 4,
  parameter int W     = 32
);

  logic               start;
  logic               op;
  logic [W*WORDS-1:0] a;
  logic [W*WORDS-1:0] b;
  logic               cin;
  logic               busy;
  logic               done;
  logic [W*WORDS-1:0] sum;
  logic               cout;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/mp_add_seq_adder.sv
// Adder32Bit: the shared 32-bit ripple-carry adder reused by the sequencer.
// Port order is (sum, cout, a, b, cin).
module Adder32Bit (
  output logic [31:0] sum,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin
);

  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[32];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit word per cycle through
// a single shared Adder32Bit, carrying between words in a local register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | processing word idx, one word per clock
// DONE  | one-cycle result-valid pulse; start here is accepted at once
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int W     = ADDER_W
) (
  input logic         clk,
  input logic         rst,
  mp_add_seq_if.slave bus
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               op_q;
  logic [W*WORDS-1:0] a_q;
  logic [W*WORDS-1:0] b_q;
  logic [W*WORDS-1:0] sum_q;
  logic               cout_q;

  logic               accept;
  logic               last_word;
  logic [W-1:0]       a_word;
  logic [W-1:0]       b_word;
  logic [W-1:0]       add_sum;
  logic               add_cout;

  assign last_word = (idx_q == LAST_IDX);
  assign a_word    = a_q[int'(idx_q)*W +: W];
  assign b_word    = (op_q == OP_SUB) ? ~b_q[int'(idx_q)*W +: W] : b_q[int'(idx_q)*W +: W];

  Adder32Bit u_adder (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_word) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured at acceptance; inputs are don't-care afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= init_carry(bus.op, bus.cin);
      op_q    <= bus.op;
      a_q     <= bus.a;
      b_q     <= bus.b;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (state_q == RUN) begin
      sum_q[int'(idx_q)*W +: W] <= add_sum;
      carry_q                   <= add_cout;
      idx_q                     <= idx_q + 1'b1;
      if (last_word) cout_q <= add_cout;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
